// File: rtl/pr_period_meter_pkg.sv
// Shared state encoding and width helpers for the pseudo-random period meter.
package pr_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WARMUP,
    CAPTURE,
    MEASURE,
    VERIFY,
    REPORT
  } state_t;

  // Widths of 32 or more saturate to a 32-bit all-ones word.
  function automatic logic [31:0] all_ones(input int unsigned w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

endpackage

// File: rtl/pr_period_meter_if.sv
// Sample/handshake bundle between a pseudo-random source and the period meter.
// The unstable flag exists only when PR_PERIOD_VERIFY_EN is defined.
interface pr_period_meter_if #(
  parameter int n  = 4,
  parameter int cw = 8
);
  logic          start;
  logic [n-1:0]  in;
  logic          in_valid;
  logic          busy;
  logic          done;
  logic [cw-1:0] period;
  logic          timeout;
  logic          full_period;
`ifdef PR_PERIOD_VERIFY_EN
  logic          unstable;

  modport master (output start, in, in_valid,
                  input  busy, done, period, timeout, full_period, unstable);
  modport slave  (input  start, in, in_valid,
                  output busy, done, period, timeout, full_period, unstable);
`else
  modport master (output start, in, in_valid,
                  input  busy, done, period, timeout, full_period);
  modport slave  (input  start, in, in_valid,
                  output busy, done, period, timeout, full_period);
`endif
endinterface

// File: rtl/pr_period_meter_sat_ctr.sv
// Saturating up-counter: clr wins over en, holds at all-ones; sat flags the ceiling.
module pr_sat_ctr
  import pr_pkg::*;
#(
  parameter int w = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [w-1:0] q,
  output logic         sat
);
  localparam logic [w-1:0] MAX = w'(all_ones(w));

  logic [w-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != MAX)) begin
      cnt_d = cnt_q + w'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q   = cnt_q;
  assign sat = (cnt_q == MAX);
endmodule

// File: rtl/pr_period_meter.sv
// Measures the recurrence period of an n-bit sample stream; done pulses one clk after the matching sample.
// Only in_valid cycles advance anything; PR_PERIOD_VERIFY_EN adds a second confirming pass and the unstable flag.
module pr_period_meter
  import pr_pkg::*;
#(
  parameter int n      = 4,
  parameter int warmup = 38,
  parameter int cw     = 8
) (
  input logic              clk,
  input logic              rst_n,
  pr_period_meter_if.slave bus
);
  localparam logic [cw-1:0] CNT_MAX  = cw'(all_ones(cw));
  localparam logic [cw-1:0] CNT_LAST = CNT_MAX - cw'(1);
  localparam logic [cw-1:0] FULL_P   = cw'(1) << n;
  localparam int            WW       = (warmup > 1) ? $clog2(warmup) : 1;
  localparam logic [WW-1:0] W_LAST   = (warmup > 0) ? WW'(warmup - 1) : '0;

  state_t        state_q, state_d;
  logic [n-1:0]  ref_q, ref_d;
  logic [cw-1:0] period_q, period_d;
  logic          timeout_q, timeout_d;
  logic          full_q, full_d;
`ifdef PR_PERIOD_VERIFY_EN
  logic          unstable_q, unstable_d;
`endif

  logic          w_clr, w_en, w_sat;
  logic          m_clr, m_en, m_sat;
  logic [WW-1:0] w_cnt;
  logic [cw-1:0] m_cnt, m_next;
  logic          hit, expire;

  pr_sat_ctr #(.w(WW)) u_warm_ctr (
    .clk(clk), .rst_n(rst_n), .clr(w_clr), .en(w_en), .q(w_cnt), .sat(w_sat)
  );

  pr_sat_ctr #(.w(cw)) u_meas_ctr (
    .clk(clk), .rst_n(rst_n), .clr(m_clr), .en(m_en), .q(m_cnt), .sat(m_sat)
  );

  // Match and expiry are judged on the same sample that bumps the count.
  assign m_next = m_cnt + cw'(1);
  assign hit    = (bus.in == ref_q);
  assign expire = (m_cnt == CNT_LAST) || m_sat;

  always_comb begin
    state_d    = state_q;
    ref_d      = ref_q;
    period_d   = period_q;
    timeout_d  = timeout_q;
    full_d     = full_q;
`ifdef PR_PERIOD_VERIFY_EN
    unstable_d = unstable_q;
`endif
    w_clr      = 1'b0;
    w_en       = 1'b0;
    m_clr      = 1'b0;
    m_en       = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d    = (warmup > 0) ? WARMUP : CAPTURE;
          timeout_d  = 1'b0;
          full_d     = 1'b0;
`ifdef PR_PERIOD_VERIFY_EN
          unstable_d = 1'b0;
`endif
          w_clr      = 1'b1;
          m_clr      = 1'b1;
        end
      end
      WARMUP: begin
        if (bus.in_valid) begin
          w_en = 1'b1;
          if ((w_cnt == W_LAST) || w_sat) state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        if (bus.in_valid) begin
          ref_d   = bus.in;
          m_clr   = 1'b1;
          state_d = MEASURE;
        end
      end
      MEASURE: begin
        if (bus.in_valid) begin
          m_en = 1'b1;
          if (hit) begin
            period_d = m_next;
`ifdef PR_PERIOD_VERIFY_EN
            m_clr    = 1'b1;
            state_d  = VERIFY;
`else
            state_d  = REPORT;
`endif
          end else if (expire) begin
            period_d  = CNT_MAX;
            timeout_d = 1'b1;
            state_d   = REPORT;
          end
        end
      end
`ifdef PR_PERIOD_VERIFY_EN
      // Second pass keeps the first period as the result and only flags disagreement.
      VERIFY: begin
        if (bus.in_valid) begin
          m_en = 1'b1;
          if (hit) begin
            unstable_d = (m_next != period_q);
            state_d    = REPORT;
          end else if (expire) begin
            timeout_d = 1'b1;
            state_d   = REPORT;
          end
        end
      end
`endif
      REPORT: begin
        full_d  = (period_q == FULL_P) && !timeout_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ref_q      <= '0;
      period_q   <= '0;
      timeout_q  <= 1'b0;
      full_q     <= 1'b0;
`ifdef PR_PERIOD_VERIFY_EN
      unstable_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      ref_q      <= ref_d;
      period_q   <= period_d;
      timeout_q  <= timeout_d;
      full_q     <= full_d;
`ifdef PR_PERIOD_VERIFY_EN
      unstable_q <= unstable_d;
`endif
    end
  end

  assign bus.busy        = (state_q == WARMUP) || (state_q == CAPTURE) ||
                           (state_q == MEASURE) || (state_q == VERIFY);
  assign bus.done        = (state_q == REPORT);
  assign bus.period      = period_q;
  assign bus.timeout     = timeout_q;
  // full_period is already valid in the done cycle, then held.
  assign bus.full_period = (state_q == REPORT) ? full_d : full_q;
`ifdef PR_PERIOD_VERIFY_EN
  assign bus.unstable    = unstable_q;
`endif
endmodule

// File: tb/tb_pr_period_meter.sv
// Directed bench for pr_period_meter: table of measurement vectors plus hand-written reset/start corner cases.
module tb_pr_period_meter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pr_period_meter_if #(.n(4), .cw(8)) b8 ();
  pr_period_meter_if #(.n(4), .cw(5)) b5 ();

  pr_period_meter #(.n(4), .warmup(38), .cw(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8));
  pr_period_meter #(.n(4), .warmup(0),  .cw(5)) dut5 (.clk(clk), .rst_n(rst_n), .bus(b5));

  typedef struct {
    int       kind;       // source pattern selector for src()
    logic [3:0] cv;       // constant value for kind 1
    int       gap;        // valid-sample spacing in cycles
    int       extra;      // 1: start while busy, 2: start in the done cycle
    int       exp_period;
    int       p2;         // second-pass period (verify build only)
    int       exp_to;
    int       exp_full;
    int       exp_cyc;    // cycles from start cycle through done cycle, single pass
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Sample source indexed by count of valid samples since start.
  function automatic logic [3:0] src(input int kind, input int idx, input logic [3:0] cv);
    int off;
    case (kind)
      0: return 4'(idx % 16);
      1: return cv;
      2: return 4'(idx % 6);
      3: return 4'(idx % 5);
      4: begin
        // period 6 on the first pass, reference value 2 recurs after 7 on the second
        if (idx <= 44) return 4'(idx % 6);
        off = idx - 44;
        if (off == 7) return 4'd2;
        if ((off % 6) == 2) return 4'd5;
        return 4'(off % 6);
      end
      5: begin
        // value 15 appears once every 40 samples; everything else cycles 0..14
        if ((idx % 40) == 0) return 4'd15;
        return 4'((idx % 40) % 15);
      end
      default: return 4'd0;
    endcase
  endfunction

  task automatic run8(input vec_t v, input int prev, input string tag);
    int idx;
    int exp_cyc;
    bit got;
    idx = 0;
    got = 1'b0;
`ifdef PR_PERIOD_VERIFY_EN
    exp_cyc = v.exp_cyc + v.gap * v.p2;
`else
    exp_cyc = v.exp_cyc;
`endif
    b8.start = 1'b1; b8.in_valid = 1'b0; b8.in = 4'h0;
    tick;
    b8.start = 1'b0;
    chk({tag, ".busy_after_start"}, int'(b8.busy), 1);
    chk({tag, ".period_held"}, int'(b8.period), prev);
    for (int off = 1; off <= 400 && !got; off++) begin
      b8.in_valid = ((off - 1) % v.gap == 0);
      b8.in       = b8.in_valid ? src(v.kind, idx, v.cv) : 4'($urandom);
      b8.start    = (v.extra == 1) && (off == 5);
      tick;
      if (b8.in_valid) idx++;
      b8.start = 1'b0;
      if (b8.done) begin
        got = 1'b1;
        chk({tag, ".cycles"},  off + 2, exp_cyc);
        chk({tag, ".busy_at_done"}, int'(b8.busy), 0);
        chk({tag, ".period"},  int'(b8.period), v.exp_period);
        chk({tag, ".timeout"}, int'(b8.timeout), v.exp_to);
        chk({tag, ".full"},    int'(b8.full_period), v.exp_full);
`ifdef PR_PERIOD_VERIFY_EN
        chk({tag, ".unstable"}, int'(b8.unstable), int'(v.p2 != v.exp_period));
`endif
        b8.in_valid = 1'b0;
        b8.start    = (v.extra == 2);
        tick;
        b8.start = 1'b0;
        chk({tag, ".done_one_cycle"}, int'(b8.done), 0);
        chk({tag, ".period_hold"}, int'(b8.period), v.exp_period);
        chk({tag, ".full_hold"}, int'(b8.full_period), v.exp_full);
        tick;
        chk({tag, ".idle_after"}, int'(b8.busy), 0);
      end
    end
    if (!got) chk({tag, ".done_seen"}, 0, 1);
  endtask

  vec_t tbl [5];
  int   prev;
  int   dones;
  int   idx5;
  bit   got5;

  initial begin
    tbl[0] = '{0, 4'h0, 1, 0, 16, 16, 0, 1, 57};
    tbl[1] = '{1, 4'hA, 1, 0, 1,  1,  0, 0, 42};
    tbl[2] = '{2, 4'h0, 2, 1, 6,  6,  0, 0, 91};
    tbl[3] = '{0, 4'h0, 3, 2, 16, 16, 0, 1, 165};
    tbl[4] = '{3, 4'h0, 1, 1, 5,  5,  0, 0, 46};

    rst_n = 1'b0;
    b8.start = 1'b0; b8.in_valid = 1'b0; b8.in = 4'h0;
    b5.start = 1'b0; b5.in_valid = 1'b0; b5.in = 4'h0;
    tick; tick;
    rst_n = 1'b1;
    tick;
    chk("rst.busy",    int'(b8.busy), 0);
    chk("rst.done",    int'(b8.done), 0);
    chk("rst.period",  int'(b8.period), 0);
    chk("rst.timeout", int'(b8.timeout), 0);
    chk("rst.full",    int'(b8.full_period), 0);
    chk("rst.busy5",   int'(b5.busy), 0);

    prev = 0;
    for (int i = 0; i < 5; i++) begin
      run8(tbl[i], prev, $sformatf("v%0d", i));
      prev = tbl[i].exp_period;
    end

    // start coincident with reset must not begin a measurement
    rst_n = 1'b0; b8.start = 1'b1;
    tick;
    rst_n = 1'b1; b8.start = 1'b0;
    tick;
    chk("rst_start.busy", int'(b8.busy), 0);
    chk("rst_start.period", int'(b8.period), 0);

    // reset in the middle of MEASURE aborts without a done pulse
    b8.start = 1'b1;
    tick;
    b8.start = 1'b0;
    for (int i = 0; i < 45; i++) begin
      b8.in_valid = 1'b1; b8.in = 4'(i % 16);
      tick;
    end
    chk("mid.busy_in_measure", int'(b8.busy), 1);
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    chk("mid.busy_after_rst", int'(b8.busy), 0);
    chk("mid.done_after_rst", int'(b8.done), 0);
    dones = 0;
    for (int i = 45; i < 85; i++) begin
      b8.in_valid = 1'b1; b8.in = 4'(i % 16);
      tick;
      if (b8.done) dones++;
    end
    b8.in_valid = 1'b0;
    chk("mid.no_done", dones, 0);
    run8(tbl[0], 0, "fresh");

    // cw=5 meter: reference recurs only after 40 samples, so it times out at 31
    idx5 = 0; got5 = 1'b0;
    b5.start = 1'b1;
    tick;
    b5.start = 1'b0;
    chk("to.busy", int'(b5.busy), 1);
    for (int off = 0; off < 200 && !got5; off++) begin
      b5.in_valid = 1'b1; b5.in = src(5, idx5, 4'h0);
      tick;
      idx5++;
      if (b5.done) begin
        got5 = 1'b1;
        chk("to.samples", idx5, 32);
        chk("to.period",  int'(b5.period), 31);
        chk("to.timeout", int'(b5.timeout), 1);
        chk("to.full",    int'(b5.full_period), 0);
      end
    end
    b5.in_valid = 1'b0;
    if (!got5) chk("to.done_seen", 0, 1);

`ifdef PR_PERIOD_VERIFY_EN
    tick;
    run8('{4, 4'h0, 1, 0, 6, 7, 0, 0, 47}, 16, "verify_shift");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pr_period_meter.md
Name: pr_period_meter

Overview:
- Downstream consumer of the pseudo-random counter (ctr_pr). Samples its n-bit output and measures the sequence period in hardware.
- Skips a warm-up run of samples, latches a reference value, then counts samples until that value recurs.
- Reports the period and flags maximal-length (2^n) sequences.
- Used for on-chip qualification of feedback LUT words.

Parameters:
- n, 4, width of observed value.
- warmup, 38, valid samples discarded before reference capture; 0 allowed.
- cw, 8, period counter width; must be >= n+1.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  pulse; begins a measurement when idle.
- in  input  n  observed counter value.
- in_valid  input  1  in is a new sample this cycle (tie to ctr_pr inc).
- busy  output  1  measurement in progress.
- done  output  1  one-cycle pulse when result is valid.
- period  output  cw  measured period; held until next start.
- timeout  output  1  no recurrence within 2^cw-1 samples; held.
- full_period  output  1  period == 2^n and timeout==0; held.

Behaviour:
- Reset (rst_n low at posedge clk): state IDLE; busy=0, done=0, period=0, timeout=0, full_period=0; internal counters and reference cleared. Reset mid-measurement aborts it with no done pulse.
- Only samples with in_valid=1 are consumed. Cycles with in_valid=0 never advance any counter.
- FSM states:
  - IDLE: start=1 → WARMUP if warmup>0, else CAPTURE. Clears timeout and full_period; period holds its old value until done. busy=1 from the cycle after start.
  - WARMUP: counts valid samples; after the warmup-th valid sample → CAPTURE.
  - CAPTURE: next valid sample latched as ref; count=0 → MEASURE.
  - MEASURE: each valid sample increments count.
    - in==ref (compared on the same sample as the increment) → period=count+1 → REPORT.
    - count+1 == 2^cw-1 without match → period=all-ones, timeout=1 → REPORT.
  - REPORT: one cycle; done=1, busy=0; full_period computed from registered period → IDLE.
- Period definition: number of valid samples from the reference sample to its next occurrence. A constant input gives period=1.
- Latency: done asserts exactly one clk after the matching valid sample.
- start while busy or in REPORT is ignored. start coincident with reset is ignored.
- Comparison uses in[n-1:0] only; hidden upstream state beyond n bits may yield periods > 2^n. These are reported normally, with full_period=0.
- The count register saturates and never wraps.

Optional Feature:
- Macro PR_PERIOD_VERIFY_EN.
- Defined:
  - After the first match, MEASURE repeats once (a second period P2) before REPORT.
  - Extra output port unstable (1 bit, reset 0, held) set when P2 != first period. period reports the first period.
  - done is delayed by P2 valid samples.
  - Timeout in either pass sets timeout=1.
- Undefined: single pass; port unstable absent.

Decomposition:
- Package pr_pkg:
  - FSM state enumeration (IDLE, WARMUP, CAPTURE, MEASURE, VERIFY, REPORT); VERIFY is used only when PR_PERIOD_VERIFY_EN is defined.
  - Helper constant function for the all-ones count of a given cw.
- One sub-module, pr_sat_ctr: cw-bit saturating counter with clr, en, and sat flag. Instanced for both the warm-up count and the measurement count.

Test Plan:
- n=4, warmup=38: in = 4-bit incrementing counter, in_valid=1 every cycle, start pulse → done after 38+1+16 samples (+1 clk); period=16, full_period=1, timeout=0.
- Constant in=4'b1010 → period=1, full_period=0.
- in cycling 0,1,2,3,4,5 repeating, in_valid toggling 1/0 → period=6; done cycle count equals 2×(valid samples)+1.
- cw=5, in = 4-bit counter feeding an 8-bit source whose low nibble repeats every 40 samples → timeout=1, period=5'b11111, no full_period.
- Assert rst_n=0 during MEASURE → next clk busy=0, no done. A fresh start gives a correct result. A start pulse while busy is ignored; one done per accepted start.
- With PR_PERIOD_VERIFY_EN: sequence period 6 then the 7th ref recurrence shifted to 7 → unstable=1, period=6.
